// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: fetch redirect priority and pending-target sequencer; REDIRECT_PERF_EN adds perf counters
module pc_redirect_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_stall,
    input  logic        validD,
    input  logic        jumpD,
    input  logic        jump_conflictD,
    input  logic [31:0] pc_jumpD,
    input  logic        branch_takenE,
    input  logic [31:0] pc_branchE,
    input  logic        excepM,
    input  logic [31:0] pc_excepM,
    input  logic [31:0] pc_plus4F,
    output logic [31:0] pc_nextF,
    output logic        pc_enF,
    output logic        stallD,
    output logic        flushD,
    output logic        flushE,
    output logic        redirect_busy,
    output logic [31:0] redirect_cnt,
    output logic [31:0] conflict_cycles
);
    typedef enum logic [1:0] {IDLE, PEND} state_t;
    state_t state, state_n;
    logic [31:0] pend_pc, pend_d;
    logic pend_ld;
    // state and latched redirect target
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pend_pc <= '0;
        end else begin
            state <= state_n;
            if (pend_ld) pend_pc <= pend_d;
        end
    end
    // redirect priority: exception, then pending target or branch, then decode jump
    always_comb begin
        pc_nextF = pc_plus4F;
        pc_enF   = 1'b0;
        stallD   = 1'b0;
        flushD   = 1'b0;
        flushE   = 1'b0;
        state_n  = state;
        pend_ld  = 1'b0;
        pend_d   = pc_jumpD;
        if (rst) begin
            state_n = IDLE;
        end else if (excepM) begin
            pc_nextF = pc_excepM;
            pc_enF   = ~inst_stall;
            flushD   = 1'b1;
            flushE   = 1'b1;
            state_n  = IDLE;
        end else if (state == PEND) begin
            pc_nextF = pend_pc;
            pc_enF   = ~inst_stall;
            state_n  = inst_stall ? PEND : IDLE;
        end else if (branch_takenE) begin
            pc_nextF = pc_branchE;
            pc_enF   = ~inst_stall;
            pend_d   = pc_branchE;
            pend_ld  = inst_stall;
            state_n  = inst_stall ? PEND : IDLE;
        end else if (jumpD && validD) begin
            if (jump_conflictD) begin
                stallD = 1'b1;
            end else begin
                pc_nextF = pc_jumpD;
                pc_enF   = ~inst_stall;
                pend_ld  = inst_stall;
                state_n  = inst_stall ? PEND : IDLE;
            end
        end else begin
            pc_enF = ~inst_stall;
        end
    end
    assign redirect_busy = (state == PEND);
`ifdef REDIRECT_PERF_EN
    logic redir_app;
    assign redir_app = pc_enF & (excepM | (state == PEND) | branch_takenE | (jumpD & validD));
    // applied-redirect and conflict-stall counters, wrapping naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_cnt    <= '0;
            conflict_cycles <= '0;
        end else begin
            if (redir_app) redirect_cnt <= redirect_cnt + 32'd1;
            if (stallD) conflict_cycles <= conflict_cycles + 32'd1;
        end
    end
`else
    assign redirect_cnt    = '0;
    assign conflict_cycles = '0;
`endif
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb_pc_redirect_ctrl: directed self-checking bench for pc_redirect_ctrl
module tb_pc_redirect_ctrl;
    logic        clk = 1'b0;
    logic        rst, inst_stall, validD, jumpD, jump_conflictD, branch_takenE, excepM;
    logic [31:0] pc_jumpD, pc_branchE, pc_excepM, pc_plus4F;
    logic [31:0] pc_nextF, redirect_cnt, conflict_cycles;
    logic        pc_enF, stallD, flushD, flushE, redirect_busy;
    int checks = 0;
    int failures = 0;
    int exp_rc = 0;
    int exp_cc = 0;

    pc_redirect_ctrl dut (
        .clk(clk), .rst(rst), .inst_stall(inst_stall), .validD(validD), .jumpD(jumpD),
        .jump_conflictD(jump_conflictD), .pc_jumpD(pc_jumpD), .branch_takenE(branch_takenE),
        .pc_branchE(pc_branchE), .excepM(excepM), .pc_excepM(pc_excepM), .pc_plus4F(pc_plus4F),
        .pc_nextF(pc_nextF), .pc_enF(pc_enF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
        .redirect_busy(redirect_busy), .redirect_cnt(redirect_cnt), .conflict_cycles(conflict_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string tag);
`ifdef REDIRECT_PERF_EN
        chk({tag, "_rc"}, redirect_cnt, exp_rc);
        chk({tag, "_cc"}, conflict_cycles, exp_cc);
`else
        chk({tag, "_rc"}, redirect_cnt, 32'd0);
        chk({tag, "_cc"}, conflict_cycles, 32'd0);
`endif
    endtask

    initial begin
        rst = 1; inst_stall = 0; validD = 1; jumpD = 1; jump_conflictD = 0; branch_takenE = 0; excepM = 0;
        pc_jumpD = 32'h1234_0000; pc_branchE = 0; pc_excepM = 0; pc_plus4F = 32'h0000_0104;
        #2;
        chk("rst_en", pc_enF, 0); chk("rst_stall", stallD, 0); chk("rst_flushD", flushD, 0);
        chk("rst_flushE", flushE, 0); chk("rst_busy", redirect_busy, 0); chk_cnt("rst");
        tick(); rst = 0; jumpD = 0;
        // jump without stall
        jumpD = 1; pc_jumpD = 32'hBFC0_0100; #2;
        chk("j_next", pc_nextF, 32'hBFC0_0100); chk("j_en", pc_enF, 1); chk("j_stall", stallD, 0);
        tick(); exp_rc = 1;
        // jr conflict for two cycles, second with fetch stall
        jump_conflictD = 1; pc_jumpD = 32'h8000_0040; #2;
        chk("cf1_stall", stallD, 1); chk("cf1_en", pc_enF, 0);
        tick(); exp_cc = 1; inst_stall = 1; #2;
        chk("cf2_stall", stallD, 1); chk("cf2_en", pc_enF, 0); chk("cf2_busy", redirect_busy, 0);
        tick(); exp_cc = 2; inst_stall = 0; jump_conflictD = 0; #2;
        chk("cf3_next", pc_nextF, 32'h8000_0040); chk("cf3_en", pc_enF, 1); chk("cf3_stall", stallD, 0);
        tick(); exp_rc = 2; jumpD = 0; #2;
        chk_cnt("cf");
        // jump under fetch stall, PEND ignores new jump and branch
        jumpD = 1; pc_jumpD = 32'h0000_3000; inst_stall = 1; #2;
        chk("pj_en", pc_enF, 0); chk("pj_busy", redirect_busy, 0);
        tick(); pc_jumpD = 32'h0000_7000; branch_takenE = 1; pc_branchE = 32'h0000_7700; #2;
        chk("pd_busy", redirect_busy, 1); chk("pd_en", pc_enF, 0);
        tick(); jumpD = 0; branch_takenE = 0; inst_stall = 0; #2;
        chk("pd_next", pc_nextF, 32'h0000_3000); chk("pd_en2", pc_enF, 1); chk("pd_busy2", redirect_busy, 1);
        tick(); exp_rc = 3; #2;
        chk("pd_idle_busy", redirect_busy, 0); chk("pd_idle_next", pc_nextF, 32'h0000_0104); chk("pd_idle_en", pc_enF, 1);
        chk_cnt("pd");
        // exception preempts PEND
        jumpD = 1; pc_jumpD = 32'h0000_4000; inst_stall = 1; tick(); jumpD = 0; inst_stall = 0;
        excepM = 1; pc_excepM = 32'hBFC0_0380; #2;
        chk("ex_busy", redirect_busy, 1); chk("ex_next", pc_nextF, 32'hBFC0_0380); chk("ex_en", pc_enF, 1);
        chk("ex_fD", flushD, 1); chk("ex_fE", flushE, 1);
        tick(); exp_rc = 4; excepM = 0; #2;
        chk("ex_busy2", redirect_busy, 0); chk("ex_drop", pc_nextF, 32'h0000_0104); chk("ex_fD2", flushD, 0);
        // branch beats a conflicting jump
        branch_takenE = 1; pc_branchE = 32'h0000_1000; jumpD = 1; jump_conflictD = 1; pc_jumpD = 32'h0000_2000; #2;
        chk("bj_next", pc_nextF, 32'h0000_1000); chk("bj_stall", stallD, 0); chk("bj_fE", flushE, 0);
        tick(); exp_rc = 5; branch_takenE = 0;
        // exception beats a conflicting jump
        excepM = 1; #2;
        chk("xj_next", pc_nextF, 32'hBFC0_0380); chk("xj_stall", stallD, 0); chk("xj_fD", flushD, 1);
        tick(); exp_rc = 6; jump_conflictD = 0; inst_stall = 1; #2;
        chk("xs_en", pc_enF, 0); chk("xs_fE", flushE, 1);
        tick(); excepM = 0; jumpD = 0; #2;
        chk("xs_busy", redirect_busy, 0);
        chk_cnt("xj");
        // branch under fetch stall
        branch_takenE = 1; pc_branchE = 32'h0000_5000; tick(); branch_takenE = 0; #2;
        chk("bs_busy", redirect_busy, 1);
        inst_stall = 0; #1;
        chk("bs_next", pc_nextF, 32'h0000_5000); chk("bs_en", pc_enF, 1);
        tick(); exp_rc = 7; #2;
        chk_cnt("bs");
        // reset while pending
        jumpD = 1; pc_jumpD = 32'h0000_6000; inst_stall = 1; tick(); jumpD = 0; inst_stall = 0; #1;
        chk("rp_busy0", redirect_busy, 1);
        rst = 1; #1;
        chk("rp_busy", redirect_busy, 0); chk("rp_en", pc_enF, 0);
        tick(); rst = 0; exp_rc = 0; exp_cc = 0; #2;
        chk("rp_next", pc_nextF, 32'h0000_0104); chk("rp_en2", pc_enF, 1); chk("rp_busy2", redirect_busy, 0);
        chk_cnt("rp");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
